// File: rtl/vga_timing_receiver.sv
// VGA sink: recovers pixel coordinates, data-enable and lock status from H_SYNC/V_SYNC/rgb.
// Optional VGA_RX_CHECKSUM_EN adds a per-frame rgb checksum (frame_sum/sum_valid).
module vga_timing_receiver #(
  // Sync pulse widths carry a _W suffix because the sync ports own the bare names.
  parameter int H_SYNC_W    = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC_W    = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       de,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        sum_valid
`endif
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0]  H_START = 10'(H_SYNC_W + H_BP);
  localparam logic [9:0]  H_END   = 10'(H_SYNC_W + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC_W + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC_W + V_BP + V_ACTIVE);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  state_t      state, state_next;
  logic [3:0]  good_frames, good_frames_next;
  logic        hs1, vs1, hs_prev, vs_prev;
  logic [7:0]  r1, g1, b1;
  logic        hs_fall, vs_fall;
  logic [9:0]  h_cnt_q, v_cnt_q, h_cnt, v_cnt;
  logic        line_armed;
  logic        line_err, frame_err, mismatch;
  logic        active, de_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      r1      <= '0;
      g1      <= '0;
      b1      <= '0;
    end else begin
      hs1     <= H_SYNC;
      vs1     <= V_SYNC;
      hs_prev <= hs1;
      vs_prev <= vs1;
      r1      <= r;
      g1      <= g;
      b1      <= b;
    end
  end

  assign hs_fall = hs_prev & ~hs1;
  assign vs_fall = vs_prev & ~vs1;

  // h_cnt/v_cnt are the positions of the pixel currently sitting in stage 1.
  always_comb begin
    h_cnt = h_cnt_q;
    v_cnt = v_cnt_q;
    if (hs_fall)
      h_cnt = '0;
    else if (h_cnt_q != 10'h3FF)
      h_cnt = h_cnt_q + 10'd1;
    if (vs_fall)
      v_cnt = '0;
    else if (hs_fall && v_cnt_q != 10'h3FF)
      v_cnt = v_cnt_q + 10'd1;
  end

  assign line_err  = hs_fall && line_armed && (state != SEARCH) &&
                     ({1'b0, h_cnt_q} + 11'd1 != H_TOT);
  assign frame_err = vs_fall && (state != SEARCH) &&
                     ({1'b0, v_cnt_q} + 11'd1 != V_TOT);
  assign mismatch  = line_err | frame_err;

  always_comb begin
    state_next       = state;
    good_frames_next = good_frames;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next       = MEASURE;
          good_frames_next = '0;
        end
      end
      MEASURE: begin
        if (mismatch) begin
          state_next = SEARCH;
        end else if (vs_fall) begin
          good_frames_next = good_frames + 4'd1;
          if (good_frames + 4'd1 >= LOCK_N)
            state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch)
          state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  // The first hsync fall after SEARCH only arms the line check unless it came with vsync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good_frames <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_armed  <= 1'b0;
    end else begin
      state       <= state_next;
      good_frames <= good_frames_next;
      h_cnt_q     <= h_cnt;
      v_cnt_q     <= v_cnt;
      if (state == SEARCH)
        line_armed <= hs_fall & vs_fall;
      else if (hs_fall)
        line_armed <= 1'b1;
    end
  end

  assign active  = (h_cnt >= H_START) && (h_cnt < H_END) &&
                   (v_cnt >= V_START) && (v_cnt < V_END);
  assign de_next = active && (state_next == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      r_o         <= '0;
      g_o         <= '0;
      b_o         <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      de          <= de_next;
      pixel_x     <= de_next ? h_cnt - H_START : 10'd0;
      pixel_y     <= de_next ? v_cnt - V_START : 10'd0;
      r_o         <= r1;
      g_o         <= g1;
      b_o         <= b1;
      frame_start <= de_next && (h_cnt == H_START) && (v_cnt == V_START);
      locked      <= (state_next == LOCKED);
      timing_err  <= mismatch;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc;
  logic [15:0] px_sum;

  assign px_sum = {8'd0, r1} + {8'd0, g1} + {8'd0, b1};

  // Accumulate only while locked; each vsync fall in LOCKED publishes and restarts the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (state != LOCKED) begin
        acc <= '0;
      end else if (vs_fall) begin
        frame_sum <= acc;
        sum_valid <= 1'b1;
        acc       <= '0;
      end else if (de_next) begin
        acc <= acc + px_sum;
      end
    end
  end
`else
  // No checksum accumulator in this build.
`endif

endmodule
